// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder over valid/ready handshakes, LSB first through a 1-bit full adder cell.
module fadder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next_state;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout;
  fadder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry), .sum(fa_sum), .cout(fa_cout));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = in_valid ? RUN : IDLE;
      RUN: next_state = (cnt == CW'(WIDTH - 1)) ? DONE : RUN;
      DONE: next_state = out_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  // the sum bit enters at the MSB so after WIDTH shifts S holds the result in order
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      s_q   <= (s_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      carry <= fa_cout;
      cnt   <= cnt + 1'b1;
    end
  assign sum  = s_q;
  assign cout = carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, cin_i = 0;
  logic [7:0] a_i = 0, b_i = 0;
  logic in_ready, out_valid, cout;
  logic [7:0] sum;
  logic w1_in_valid = 0, w1_out_ready = 0, w1_a = 0, w1_b = 0, w1_cin = 0;
  logic w1_in_ready, w1_out_valid, w1_sum, w1_cout;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a_i), .b(b_i),
    .cin(cin_i), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .a(w1_a), .b(w1_b),
    .cin(w1_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready), .sum(w1_sum), .cout(w1_cout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [8:0] exp, input string tag);
    int n;
    chk({tag, "_rdy"}, in_ready, 1);
    a_i = x; b_i = y; cin_i = c; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_res"}, {cout, sum}, exp);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  initial begin
    int n, n_acc, n_res;
    int acc_t [2];
    logic [8:0] res [2];
    logic rdy;
    logic [7:0] x, y;
    logic c;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", {cout, sum}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    do_op(8'h35, 8'h4A, 1'b0, 9'h07F, "t1");
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, "t2a");
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, "t2b");
    // result held while consumer stalls, in_valid toggling
    a_i = 8'h9C; b_i = 8'h21; cin_i = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_first", {cout, sum}, 9'h0BE);
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid; a_i = 8'(k * 37); b_i = 8'(k * 11 + 5);
      @(posedge clk); #1;
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_res", {cout, sum}, 9'h0BE);
      chk("t3_hold_rdy", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("t3_idle_rdy", in_ready, 1);
    chk("t3_idle_valid", out_valid, 0);
    chk("t3_idle_keep", {cout, sum}, 9'h0BE);
    @(posedge clk); #1;
    chk("t3_no_accept", in_ready, 1);
    // asynchronous reset mid-run
    a_i = 8'hFF; b_i = 8'h01; cin_i = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t4_valid", out_valid, 0);
    chk("t4_res", {cout, sum}, 0);
    chk("t4_rdy", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    do_op(8'h01, 8'h01, 1'b0, 9'h002, "t4_after");
    // back-to-back with in_valid and out_ready held high
    a_i = 8'h12; b_i = 8'h34; cin_i = 1; in_valid = 1; out_ready = 1;
    n_acc = 0; n_res = 0;
    for (int e = 0; e < 30; e++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid && n_acc < 2) begin
        acc_t[n_acc] = e;
        n_acc++;
        if (n_acc == 1) begin a_i = 8'hA0; b_i = 8'h7F; cin_i = 0; end
        else in_valid = 0;
      end
      if (out_valid && n_res < 2) begin
        res[n_res] = {cout, sum};
        n_res++;
      end
    end
    out_ready = 0; in_valid = 0;
    chk("t5_n_acc", n_acc, 2);
    chk("t5_n_res", n_res, 2);
    if (n_acc == 2) chk("t5_spacing", acc_t[1] - acc_t[0], 10);
    if (n_res == 2) begin
      chk("t5_res0", res[0], 9'h047);
      chk("t5_res1", res[1], 9'h11F);
    end
    // WIDTH=1 full-adder truth table, latency 1
    for (int v = 0; v < 8; v++) begin
      w1_a = v[2]; w1_b = v[1]; w1_cin = v[0]; w1_in_valid = 1;
      @(posedge clk); #1;
      w1_in_valid = 0;
      chk("w1_run", w1_out_valid, 0);
      @(posedge clk); #1;
      chk("w1_lat", w1_out_valid, 1);
      chk("w1_res", {w1_cout, w1_sum}, (v[2] + v[1] + v[0]));
      w1_out_ready = 1;
      @(posedge clk); #1;
      w1_out_ready = 0;
    end
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255)); c = 1'($urandom_range(0, 1));
      do_op(x, y, c, {1'b0, x} + {1'b0, y} + {8'b0, c}, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
